mux8way_rr: RTL and testbench

- Sequential 8-to-1 collector: the fan-in counterpart of the 8-way demultiplexer.
- Eight valid/ready source channels of WIDTH-bit words are round-robin arbitrated onto one registered output channel.
- Each output word is tagged with the 3-bit index of its source, so a downstream 8-way demux can route it back out.
- Sits between per-channel producers (e.g. memory-mapped device ports) and a single shared consumer.

---
 rtl/mux8way_rr.sv | 111 +++++++++++
 tb/tb_mux8way_rr.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mux8way_rr.sv
// Eight valid/ready sources round-robin arbitrated into one registered, source-tagged output.
// Define MUX8WAY_RR_LOCK_EN to keep packets (in_last-terminated) from different sources contiguous.
module mux8way_rr #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_valid,
    input  logic [8*WIDTH-1:0]   in_data,
    input  logic [7:0]           in_last,
    output logic [7:0]           in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [2:0]           out_sel,
    input  logic                 out_ready
);

    logic [2:0]       ptr_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [2:0]       out_sel_reg;

    logic [WIDTH-1:0] words [8];
    logic [7:0]       elig;
    logic [7:0]       rot;
    logic             found;
    logic [2:0]       win_off;
    logic [2:0]       win_idx;
    logic             slot_free;
    logic             take;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_words
            assign words[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef MUX8WAY_RR_LOCK_EN
    logic       lock_reg;
    logic [2:0] lock_ch_reg;

    // A locked channel is the only candidate, whether or not it is valid right now.
    assign elig = lock_reg ? (in_valid & (8'b1 << lock_ch_reg)) : in_valid;
`else
    logic [7:0] unused_last;

    assign unused_last = in_last;
    assign elig        = in_valid;
`endif

    // rot[k] is the eligibility of channel ptr+k, so the lowest set bit wins.
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rot
            assign rot[gi] = elig[ptr_reg + 3'(gi)];
        end
    endgenerate

    always_comb begin
        found   = 1'b0;
        win_off = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (rot[k]) begin
                found   = 1'b1;
                win_off = 3'(k);
            end
        end
    end

    assign win_idx   = ptr_reg + win_off;
    assign slot_free = !out_valid_reg || out_ready;
    // Nothing is accepted during reset, since the captured word would be thrown away.
    assign in_ready  = (found && slot_free && !rst) ? (8'b1 << win_idx) : 8'b0;
    assign take      = |in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg       <= 3'd0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sel_reg   <= 3'd0;
`ifdef MUX8WAY_RR_LOCK_EN
            lock_reg      <= 1'b0;
            lock_ch_reg   <= 3'd0;
`endif
        end else if (take) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= words[win_idx];
            out_sel_reg   <= win_idx;
`ifdef MUX8WAY_RR_LOCK_EN
            // The pointer moves on only once the whole packet has gone through.
            if (in_last[win_idx]) begin
                lock_reg <= 1'b0;
                ptr_reg  <= win_idx + 3'd1;
            end else begin
                lock_reg    <= 1'b1;
                lock_ch_reg <= win_idx;
            end
`else
            ptr_reg <= win_idx + 3'd1;
`endif
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_mux8way_rr.sv
// Bench for mux8way_rr: directed scenarios plus random traffic against a round-robin reference model.
module tb_mux8way_rr;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [7:0]     in_valid;
    logic [8*W-1:0] in_data;
    logic [7:0]     in_last;
    logic [7:0]     in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [2:0]     out_sel;
    logic           out_ready;

    int nvec = 0;
    int nerr = 0;

    // reference state: what the output register and arbiter should hold
    int       m_ptr;
    int       m_ov;
    int       m_od;
    int       m_os;
    int       m_lock;
    int       m_lockch;
    logic [7:0] last_ready;

    mux8way_rr #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_sel  (out_sel),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_ptr = 0; m_ov = 0; m_od = 0; m_os = 0; m_lock = 0; m_lockch = 0;
    endfunction

    // Returns the channel the arbiter should accept this cycle, or -1.
    function automatic int model_pick();
        int c;
        if (rst) return -1;
        if (m_ov != 0 && !out_ready) return -1;
        for (int k = 0; k < 8; k++) begin
            c = (m_ptr + k) % 8;
            if (in_valid[c] && (m_lock == 0 || c == m_lockch)) return c;
        end
        return -1;
    endfunction

    function automatic void model_clock(input int w);
        if (rst) begin
            model_reset();
        end else if (w >= 0) begin
            m_ov = 1;
            m_od = int'(in_data[w*W +: W]);
            m_os = w;
`ifdef MUX8WAY_RR_LOCK_EN
            if (in_last[w]) begin
                m_lock = 0;
                m_ptr  = (w + 1) % 8;
            end else begin
                m_lock   = 1;
                m_lockch = w;
            end
`else
            m_ptr = (w + 1) % 8;
`endif
        end else if (m_ov != 0 && out_ready) begin
            m_ov = 0;
        end
    endfunction

    // One clock: drive, compare everything against the model mid-cycle, advance the model.
    task automatic cycle(input logic [7:0] v, input logic [7:0] l, input logic ordy, input logic r);
        int w;
        logic [7:0] exp_ready;
        in_valid = v; in_last = l; out_ready = ordy; rst = r;
        @(negedge clk);
        w = model_pick();
        exp_ready = (w >= 0) ? (8'b1 << w) : 8'b0;
        check("in_ready", {24'b0, in_ready}, {24'b0, exp_ready});
        check("out_valid", {31'b0, out_valid}, 32'(m_ov));
        check("out_data", {16'b0, out_data}, 32'(m_od));
        check("out_sel", {29'b0, out_sel}, 32'(m_os));
        last_ready = in_ready;
        model_clock(w);
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int ch, input logic [W-1:0] val);
        in_data[ch*W +: W] = val;
    endtask

    initial begin
        logic [7:0] l1;
        int exp5 [4];

        in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", {16'b0, out_data}, 32'd0);
        check("rst_out_sel", {29'b0, out_sel}, 32'd0);

        // 1: lone channel 3
        set_word(3, 16'h1234);
        cycle(8'h08, 8'hFF, 1'b1, 1'b0);
        check("t1_ready", {24'b0, last_ready}, 32'h08);
        check("t1_out_valid", {31'b0, out_valid}, 32'd1);
        check("t1_out_data", {16'b0, out_data}, 32'h1234);
        check("t1_out_sel", {29'b0, out_sel}, 32'd3);
        cycle(8'h18, 8'hFF, 1'b1, 1'b0);
        check("t1_ptr4", {24'b0, last_ready}, 32'h10);

        // 2: all channels valid, full rate with wrap
        for (int i = 0; i < 8; i++) set_word(i, 16'(16'h00A0 + i));
        cycle(8'h00, 8'hFF, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            cycle(8'hFF, 8'hFF, 1'b1, 1'b0);
            check($sformatf("t2_sel_%0d", k), {29'b0, out_sel}, 32'(k % 8));
            check($sformatf("t2_data_%0d", k), {16'b0, out_data}, 32'(16'h00A0 + (k % 8)));
        end

        // 3: stall with channels 2 and 5
        cycle(8'h00, 8'hFF, 1'b1, 1'b1);
        cycle(8'h24, 8'hFF, 1'b0, 1'b0);
        check("t3_first", {29'b0, out_sel}, 32'd2);
        for (int k = 0; k < 4; k++) begin
            cycle(8'h24, 8'hFF, 1'b0, 1'b0);
            check("t3_stall_ready", {24'b0, last_ready}, 32'd0);
            check("t3_stall_sel", {29'b0, out_sel}, 32'd2);
            check("t3_stall_data", {16'b0, out_data}, 32'h00A2);
        end
        cycle(8'h24, 8'hFF, 1'b1, 1'b0);
        check("t3_release_ready", {24'b0, last_ready}, 32'h20);
        check("t3_release_sel", {29'b0, out_sel}, 32'd5);

        // 4: reset while holding a word
        cycle(8'h00, 8'hFF, 1'b1, 1'b1);
        cycle(8'h40, 8'hFF, 1'b0, 1'b0);
        check("t4_held", {31'b0, out_valid}, 32'd1);
        cycle(8'h40, 8'hFF, 1'b0, 1'b1);
        check("t4_rst_ready", {24'b0, last_ready}, 32'd0);
        check("t4_rst_valid", {31'b0, out_valid}, 32'd0);
        check("t4_rst_data", {16'b0, out_data}, 32'd0);
        check("t4_rst_sel", {29'b0, out_sel}, 32'd0);
        cycle(8'h41, 8'hFF, 1'b1, 1'b0);
        check("t4_ptr0", {24'b0, last_ready}, 32'h01);
        cycle(8'h40, 8'hFF, 1'b1, 1'b0);
        check("t4_reaccept", {29'b0, out_sel}, 32'd6);

        // 5: three-word packet on channel 1 against a busy channel 0
`ifdef MUX8WAY_RR_LOCK_EN
        exp5 = '{1, 1, 1, 0};
`else
        exp5 = '{1, 0, 1, 0};
`endif
        cycle(8'h00, 8'hFF, 1'b1, 1'b1);
        cycle(8'h01, 8'hFF, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            l1 = (k == 2) ? 8'h03 : 8'h01;
            cycle(8'h03, l1, 1'b1, 1'b0);
            check($sformatf("t5_sel_%0d", k), {29'b0, out_sel}, 32'(exp5[k]));
        end

        // 6: idle stretch leaves the pointer alone (it now points at channel 1)
        for (int k = 0; k < 10; k++) begin
            cycle(8'h00, 8'hFF, 1'b1, 1'b0);
            check("t6_idle_ready", {24'b0, last_ready}, 32'd0);
            check("t6_idle_valid", {31'b0, out_valid}, 32'd0);
        end
        cycle(8'h03, 8'hFF, 1'b1, 1'b0);
        check("t6_ptr_kept", {24'b0, last_ready}, 32'h02);

        // random traffic, occasional reset
        for (int n = 0; n < 600; n++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            cycle(8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 59) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
